// File: rtl/bp_fe_mem_pkt_arbiter.sv
// bp_fe_mem_pkt_arbiter
//
// Round-robin arbiter that shares the I$ fill/maintenance packet port among
// several engine-side packet sources (LCE fill, uncached, debug/config).
// One requester is granted at a time. A multi-beat fill burst holds the grant
// until its last beat, so fill beats from different sources never interleave.
// A runaway burst is force-released after max_beats_p accepted beats.
//
// Ports:
//   clk_i      clock
//   reset_i    synchronous, active-high reset
//   pkt_i      packed request packets, requester k at [k*pkt_width_p +: pkt_width_p]
//   v_i        per-requester valid
//   last_i     per-requester "this beat ends the burst"
//   yumi_o     per-requester accept (one-hot or zero)
//   flush_i    abandon the current lock (I$ fence / state reset)
//   pkt_o      granted packet beat
//   v_o        granted packet valid
//   yumi_i     downstream accepts pkt_o this cycle
//   owner_o    current grant index
//   locked_o   burst lock held
//   overrun_o  one-cycle pulse when a burst is force-released at the beat limit

module bp_fe_mem_pkt_arbiter #(
    parameter int num_req_p   = 3,
    parameter int pkt_width_p = 64,
    parameter int max_beats_p = 8,
    localparam int owner_w    = $clog2(num_req_p),
    localparam int cnt_w      = $clog2(max_beats_p + 1)
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic [num_req_p*pkt_width_p-1:0]  pkt_i,
    input  logic [num_req_p-1:0]              v_i,
    input  logic [num_req_p-1:0]              last_i,
    output logic [num_req_p-1:0]              yumi_o,
    input  logic                              flush_i,
    output logic [pkt_width_p-1:0]            pkt_o,
    output logic                              v_o,
    input  logic                              yumi_i,
    output logic [owner_w-1:0]                owner_o,
    output logic                              locked_o,
    output logic                              overrun_o
);

    typedef enum logic {e_idle, e_locked} state_e;

    localparam logic [owner_w-1:0] LAST_IDX  = owner_w'(num_req_p - 1);
    localparam logic [owner_w:0]   NUM_REQ_W = (owner_w + 1)'(num_req_p);
    localparam logic [cnt_w-1:0]   CNT_LIMIT = cnt_w'(max_beats_p - 1);

    state_e             state_r;
    logic [owner_w-1:0] rr_ptr_r;
    logic [owner_w-1:0] owner_r;
    logic [cnt_w-1:0]   beat_cnt_r;

    logic [owner_w-1:0]     rr_grant;
    logic [owner_w-1:0]     grant;
    logic                   v_raw;
    logic                   accept;
    logic                   last_g;
    logic [cnt_w-1:0]       cur_cnt;
    logic                   release_g;
    logic [pkt_width_p-1:0] pkt_arr [num_req_p];

    // Index following k in round-robin order, wrapping at num_req_p.
    function automatic logic [owner_w-1:0] next_idx(input logic [owner_w-1:0] k);
        return (k == LAST_IDX) ? '0 : k + 1'b1;
    endfunction

    for (genvar k = 0; k < num_req_p; k++) begin : g_slice
        assign pkt_arr[k] = pkt_i[k*pkt_width_p +: pkt_width_p];
    end

    // Priority scan starting at rr_ptr_r; first valid requester wins.
    always_comb begin
        logic             found;
        logic [owner_w:0] sum;
        rr_grant = '0;
        found    = 1'b0;
        sum      = '0;
        for (int i = 0; i < num_req_p; i++) begin
            sum = {1'b0, rr_ptr_r} + (owner_w + 1)'(i);
            if (sum >= NUM_REQ_W) sum = sum - NUM_REQ_W;
            if (!found && v_i[sum[owner_w-1:0]]) begin
                found    = 1'b1;
                rr_grant = sum[owner_w-1:0];
            end
        end
    end

    // While locked only the owner is eligible; a low owner valid is a bubble,
    // not a reason to hand the port to someone else.
    assign grant   = (state_r == e_locked) ? owner_r : rr_grant;
    assign v_raw   = (state_r == e_locked) ? v_i[owner_r] : |v_i;
    assign v_o     = v_raw & ~flush_i & ~reset_i;
    assign accept  = v_o & yumi_i;
    assign last_g  = last_i[grant];
    assign owner_o = grant;
    assign pkt_o   = reset_i ? '0 : pkt_arr[grant];

    // In idle the granted beat is beat zero of a potential burst, which lets
    // max_beats_p=1 release every accepted beat through the same path.
    assign cur_cnt   = (state_r == e_locked) ? beat_cnt_r : '0;
    assign release_g = accept & (last_g | (cur_cnt == CNT_LIMIT));
    assign overrun_o = release_g & ~last_g;
    assign locked_o  = (state_r == e_locked) & ~reset_i;

    for (genvar k = 0; k < num_req_p; k++) begin : g_yumi
        assign yumi_o[k] = accept & (grant == owner_w'(k));
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r    <= e_idle;
            rr_ptr_r   <= '0;
            owner_r    <= '0;
            beat_cnt_r <= '0;
        end else if (flush_i) begin
            // Drop the lock; the requester re-issues its burst from the start.
            state_r    <= e_idle;
            beat_cnt_r <= '0;
        end else if (accept) begin
            if (release_g) begin
                state_r    <= e_idle;
                beat_cnt_r <= '0;
                rr_ptr_r   <= next_idx(grant);
            end else if (state_r == e_idle) begin
                state_r    <= e_locked;
                owner_r    <= grant;
                beat_cnt_r <= cnt_w'(1);
            end else begin
                beat_cnt_r <= beat_cnt_r + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bp_fe_mem_pkt_arbiter.sv
module tb_bp_fe_mem_pkt_arbiter;

    logic         clk_i = 1'b0;
    logic         reset_i;
    logic [191:0] pkt_i;
    logic [2:0]   v_i;
    logic [2:0]   last_i;
    logic [2:0]   yumi_o;
    logic         flush_i;
    logic [63:0]  pkt_o;
    logic         v_o;
    logic         yumi_i;
    logic [1:0]   owner_o;
    logic         locked_o;
    logic         overrun_o;

    int checks = 0;
    int errors = 0;
    int seq    = 0;
    logic [63:0] exp_q [$];

    bp_fe_mem_pkt_arbiter #(.num_req_p(3), .pkt_width_p(64), .max_beats_p(8)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .pkt_i(pkt_i), .v_i(v_i), .last_i(last_i),
        .yumi_o(yumi_o), .flush_i(flush_i), .pkt_o(pkt_o), .v_o(v_o), .yumi_i(yumi_i),
        .owner_o(owner_o), .locked_o(locked_o), .overrun_o(overrun_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [63:0] mk(input int k, input int s);
        return {8'(k + 1), 24'h5A5A5A, 32'(s)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at negedge, check combinational outputs 1 time unit later.
    // hold keeps the packet payload unchanged from the previous cycle.
    task automatic step(input logic [2:0] v, input logic [2:0] last, input bit yumi,
                        input bit flush, input bit hold, input bit ev, input int eo,
                        input logic [2:0] ey, input bit el, input bit eov);
        logic [63:0] sb;
        @(negedge clk_i);
        if (!hold) seq++;
        reset_i = 1'b0;
        v_i     = v;
        last_i  = last;
        yumi_i  = yumi;
        flush_i = flush;
        pkt_i   = {mk(2, seq), mk(1, seq), mk(0, seq)};
        if (ey != 3'b000) exp_q.push_back(mk(eo, seq));
        #1;
        chk("v_o", 64'(v_o), 64'(ev));
        chk("yumi_o", 64'(yumi_o), 64'(ey));
        chk("locked_o", 64'(locked_o), 64'(el));
        chk("overrun_o", 64'(overrun_o), 64'(eov));
        if (ev || el) chk("owner_o", 64'(owner_o), 64'(eo));
        if (ev) chk("pkt_o", pkt_o, mk(eo, seq));
        if (yumi_o != 3'b000) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_accept", 64'(yumi_o), 64'(0));
            end else begin
                sb = exp_q.pop_front();
                chk("sb_pkt", pkt_o, sb);
            end
        end
    endtask

    initial begin
        reset_i = 1'b1;
        v_i     = 3'b111;
        last_i  = 3'b111;
        yumi_i  = 1'b1;
        flush_i = 1'b0;
        pkt_i   = {mk(2, 0), mk(1, 0), mk(0, 0)};

        // Reset: all outputs quiet even with requests and yumi present.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            #1;
            chk("rst_v_o", 64'(v_o), 64'(0));
            chk("rst_yumi_o", 64'(yumi_o), 64'(0));
            chk("rst_locked_o", 64'(locked_o), 64'(0));
            chk("rst_overrun_o", 64'(overrun_o), 64'(0));
            chk("rst_pkt_o", pkt_o, 64'(0));
        end

        // Single-beat round robin: 0,1,2 then back to 0.
        step(3'b111, 3'b111, 1, 0, 0, 1, 0, 3'b001, 0, 0);
        step(3'b111, 3'b111, 1, 0, 0, 1, 1, 3'b010, 0, 0);
        step(3'b111, 3'b111, 1, 0, 0, 1, 2, 3'b100, 0, 0);
        step(3'b111, 3'b111, 0, 0, 0, 1, 0, 3'b000, 0, 0);

        // Move pointer to 1, then requester 1 four-beat burst with others valid.
        step(3'b111, 3'b111, 1, 0, 0, 1, 0, 3'b001, 0, 0);
        step(3'b111, 3'b000, 1, 0, 0, 1, 1, 3'b010, 0, 0);
        step(3'b111, 3'b000, 1, 0, 0, 1, 1, 3'b010, 1, 0);
        step(3'b111, 3'b000, 1, 0, 0, 1, 1, 3'b010, 1, 0);
        step(3'b111, 3'b010, 1, 0, 0, 1, 1, 3'b010, 1, 0);
        step(3'b111, 3'b111, 0, 0, 0, 1, 2, 3'b000, 0, 0);

        // Pointer to 0, then requester 0 burst with a two-cycle bubble.
        step(3'b111, 3'b111, 1, 0, 0, 1, 2, 3'b100, 0, 0);
        step(3'b101, 3'b000, 1, 0, 0, 1, 0, 3'b001, 0, 0);
        step(3'b100, 3'b000, 1, 0, 0, 0, 0, 3'b000, 1, 0);
        step(3'b100, 3'b000, 1, 0, 0, 0, 0, 3'b000, 1, 0);
        step(3'b101, 3'b001, 1, 0, 0, 1, 0, 3'b001, 1, 0);
        step(3'b111, 3'b111, 0, 0, 0, 1, 1, 3'b000, 0, 0);

        // Requester 2 never signals last: forced release on beat 8.
        step(3'b101, 3'b000, 1, 0, 0, 1, 2, 3'b100, 0, 0);
        for (int b = 2; b <= 7; b++) step(3'b101, 3'b000, 1, 0, 0, 1, 2, 3'b100, 1, 0);
        step(3'b101, 3'b000, 1, 0, 0, 1, 2, 3'b100, 1, 1);
        step(3'b101, 3'b000, 0, 0, 0, 1, 0, 3'b000, 0, 0);

        // Pointer to 1, requester 1 burst flushed on beat 3; 1 wins again.
        step(3'b111, 3'b111, 1, 0, 0, 1, 0, 3'b001, 0, 0);
        step(3'b111, 3'b000, 1, 0, 0, 1, 1, 3'b010, 0, 0);
        step(3'b111, 3'b000, 1, 0, 0, 1, 1, 3'b010, 1, 0);
        step(3'b111, 3'b000, 1, 1, 0, 0, 1, 3'b000, 1, 0);
        step(3'b111, 3'b111, 0, 0, 0, 1, 1, 3'b000, 0, 0);

        // Stall with only requester 0 valid: grant and packet hold steady.
        step(3'b001, 3'b111, 0, 0, 0, 1, 0, 3'b000, 0, 0);
        for (int i = 0; i < 4; i++) step(3'b001, 3'b111, 0, 0, 1, 1, 0, 3'b000, 0, 0);
        // Requester 1 now valid and ahead of 0 in rotation (pointer is 1).
        step(3'b011, 3'b111, 0, 0, 1, 1, 1, 3'b000, 0, 0);
        step(3'b011, 3'b111, 1, 0, 0, 1, 1, 3'b010, 0, 0);
        step(3'b011, 3'b111, 1, 0, 0, 1, 0, 3'b001, 0, 0);

        // yumi_i with nothing valid is ignored.
        step(3'b000, 3'b000, 1, 0, 0, 0, 0, 3'b000, 0, 0);
        step(3'b110, 3'b111, 1, 0, 0, 1, 1, 3'b010, 0, 0);

        chk("sb_drained", 64'(exp_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bp_fe_mem_pkt_arbiter.md
Name: bp_fe_mem_pkt_arbiter

Overview:
Round-robin arbiter that shares the I$ fill/maintenance packet port among several engine-side requesters, e.g. the LCE fill path, the uncached path, and the debug/config path. It grants one requester at a time. It holds the grant across a multi-beat fill burst, so I$ fill beats from different requesters never interleave. It sits between the cache-engine packet sources and the I$ data/tag/stat mem packet inputs of the front end.

Parameters:
num_req_p, 3, number of requesters (>=2)
pkt_width_p, 64, width of one packet beat
max_beats_p, 8, maximum beats per locked burst; equals icache_block_width_p/icache_fill_width_p

Ports:
clk_i  input  1  clock
reset_i  input  1  synchronous, active-high reset
pkt_i  input  num_req_p*pkt_width_p  packed packets; requester k occupies bits [k*pkt_width_p +: pkt_width_p]
v_i  input  num_req_p  per-requester valid
last_i  input  num_req_p  per-requester "this beat ends the burst"
yumi_o  output  num_req_p  per-requester accept; one-hot or zero
flush_i  input  1  abandon current lock (I$ fence / state reset)
pkt_o  output  pkt_width_p  granted packet beat
v_o  output  1  granted packet valid
yumi_i  input  1  downstream accepts pkt_o this cycle
owner_o  output  $clog2(num_req_p)  current grant index
locked_o  output  1  burst lock held
overrun_o  output  1  one-cycle pulse when a burst is force-released at max_beats_p

Behaviour:
- Single clock clk_i; reset is synchronous and active-high on reset_i. All state updates on posedge clk_i.
- State: e_idle, e_locked. Registers: state_r, rr_ptr_r (next-highest-priority index), owner_r, beat_cnt_r (width $clog2(max_beats_p+1)).
- Reset values: state_r=e_idle, rr_ptr_r=0, owner_r=0, beat_cnt_r=0. While reset_i=1: v_o=0, yumi_o=0, locked_o=0, overrun_o=0, pkt_o=0.
- Arbitration is zero latency and combinational from v_i to v_o/pkt_o.
- e_idle:
  - grant = first k with v_i[k]=1, scanning rr_ptr_r, rr_ptr_r+1, ... modulo num_req_p.
  - v_o = |v_i; pkt_o = pkt_i slice of grant; owner_o = grant.
  - If v_o & yumi_i & last_i[grant]: stay e_idle; rr_ptr_r <= (grant+1) mod num_req_p.
  - If v_o & yumi_i & ~last_i[grant]: go to e_locked; owner_r <= grant; beat_cnt_r <= 1.
  - If no accept: no state change and no rr_ptr_r change, so grant may move to a newly valid higher-priority requester next cycle.
- e_locked:
  - Only owner_r is eligible. v_o = v_i[owner_r]; pkt_o = owner slice; owner_o = owner_r; locked_o=1.
  - Other requesters get no yumi, even while the owner's v_i is low (bubble allowed; lock held).
  - On v_o & yumi_i: beat_cnt_r <= beat_cnt_r+1.
  - Release on an accepted beat when last_i[owner_r]=1, or when beat_cnt_r==max_beats_p-1. On release: go to e_idle, beat_cnt_r <= 0, rr_ptr_r <= (owner_r+1) mod num_req_p.
  - If release is caused by the beat limit with last_i[owner_r]=0, overrun_o=1 in that cycle.
- yumi_o[k] = yumi_i & v_o & (owner_o==k). yumi_i while v_o=0 is ignored with no state change.
- flush_i (highest priority, after reset):
  - Masks v_o and yumi_o to 0 in the same cycle.
  - Next state is e_idle with beat_cnt_r=0. rr_ptr_r is unchanged.
- A mid-burst reset or flush drops the lock. The partial burst is never resumed by the arbiter; the requester re-issues.
- max_beats_p=1: every accepted beat releases. overrun_o fires whenever last_i=0.
- pkt_o must be held stable while v_o=1 and yumi_i=0 if the inputs are stable (no grant switch in e_locked).

Test Plan:
- Reset then v_i=3'b111, last_i=3'b111, yumi_i=1 for 3 cycles -> owner_o sequence 0,1,2; yumi_o 001,010,100; rr_ptr_r returns to 0.
- Requester 1 burst of 4 beats (last_i[1] on beat 4) while v_i[0],v_i[2] held high -> owner_o=1 for 4 accepted beats; locked_o=1 after beat 1; next grant is 2.
- Requester 0 locked, v_i[0] drops for 2 cycles mid-burst with v_i[2]=1 -> v_o=0, yumi_o=0 for those cycles; lock kept; burst completes from requester 0.
- max_beats_p=8, requester 2 never asserts last_i -> release after 8th accepted beat; overrun_o pulses on that beat; next grant is 0.
- flush_i asserted on beat 3 of a requester-1 burst -> v_o=0 that cycle; state e_idle next cycle; rr_ptr_r unchanged, so requester 1 can win again.
- yumi_i=0 with v_i=3'b001 for 5 cycles, then v_i=3'b011 -> no state change; pkt_o stable; grant follows the round-robin order from rr_ptr_r.
